// File: rtl/argmax_classifier_pkg.sv
// Shared types and build-time defaults for the argmax classifier stage.
// Defaults follow the network-wide defines when they are present.
`ifndef numNeuronLayer4
`define numNeuronLayer4 10
`endif

`ifndef dataWidth
`define dataWidth 16
`endif

package argmax_classifier_pkg;

    localparam int NUM_IN_DEF     = `numNeuronLayer4;
    localparam int DATA_WIDTH_DEF = `dataWidth;

    localparam int IDX_WIDTH_DEF   = 4;
    localparam int FRAME_CNT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/argmax_classifier.sv
// Terminal argmax stage: tracks the running signed maximum over a serial
// frame of NUM_IN beats and emits the winning index/value as a 1-cycle pulse.
module argmax_classifier
    import argmax_classifier_pkg::*;
#(
    parameter int NUM_IN     = NUM_IN_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_WIDTH  = IDX_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       i_valid,
    input  logic                       i_flush,
    output logic [IDX_WIDTH-1:0]       o_class,
    output logic [DATA_WIDTH-1:0]      o_max,
    output logic                       o_valid,
    output logic                       o_busy,
    output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_IN - 1);

    state_e state_q, state_d;

    logic                        busy_q;
    logic [IDX_WIDTH-1:0]        cnt_q;
    logic signed [DATA_WIDTH-1:0] cur_max_q;
    logic [IDX_WIDTH-1:0]        cur_idx_q;
    logic signed [DATA_WIDTH-1:0] max_q;
    logic [IDX_WIDTH-1:0]        class_q;
    logic                        valid_q;
    logic [FRAME_CNT_WIDTH-1:0]  frame_cnt_q;

    logic                        accept;
    logic                        last_beat;
    logic                        take_new;
    logic signed [DATA_WIDTH-1:0] data_s;
    logic signed [DATA_WIDTH-1:0] win_max;
    logic [IDX_WIDTH-1:0]        win_idx;

    // Flush always wins over a coincident beat, so a beat counts only without it.
    assign accept    = i_valid && !i_flush;
    assign data_s    = $signed(i_data);
    assign last_beat = (state_q == ST_ACCUM) && (cnt_q == LAST_IDX);

    // The first beat seeds the maximum; later beats replace it only when strictly
    // greater, which makes the lowest index win among equal values.
    assign take_new = (state_q == ST_IDLE) || (data_s > cur_max_q);
    assign win_max  = take_new ? data_s : cur_max_q;
    assign win_idx  = !take_new             ? cur_idx_q :
                      (state_q == ST_IDLE)  ? '0        : cnt_q;

    always_comb begin
        // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (i_flush || (accept && last_beat)) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking <= so every register samples the pre-edge values of the others.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_ACCUM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            cur_max_q   <= '0;
            cur_idx_q   <= '0;
            max_q       <= '0;
            class_q     <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (i_flush) begin
                cnt_q <= '0;
            end else if (accept) begin
                cur_max_q <= win_max;
                cur_idx_q <= win_idx;
                if (last_beat) begin
                    cnt_q       <= '0;
                    max_q       <= win_max;
                    class_q     <= win_idx;
                    valid_q     <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
                end else begin
                    cnt_q <= cnt_q + IDX_WIDTH'(1);
                end
            end
        end
    end

    assign o_class     = class_q;
    assign o_max       = max_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: a table of frames with expected winners
// plus hand-written flush, reset and back-to-back sequences.
module tb_argmax_classifier;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          i_flush;
    logic [IW-1:0] o_class;
    logic [DW-1:0] o_max;
    logic          o_valid;
    logic          o_busy;
    logic [15:0]   o_frame_cnt;

    always #5 clk = ~clk;

    argmax_classifier #(
        .NUM_IN     (N),
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_flush     (i_flush),
        .o_class     (o_class),
        .o_max       (o_max),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_frame_cnt (o_frame_cnt)
    );

    typedef struct packed {
        logic [N-1:0][DW-1:0] data;
        logic                 gaps;
        logic [IW-1:0]        exp_class;
        logic [DW-1:0]        exp_max;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    int vals [NV][N] = '{
        '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4},
        '{-32768, -2, -1, -32767, -32768, -32768, -32768, -32768, -32768, -32768},
        '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4},
        '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5},
        '{32767, -1, 0, 100, 32767, -32768, 5, 5, 5, 32766},
        '{0, 10, 20, 30, 40, 50, 60, 70, 80, 100},
        '{-7, -7, -3, -3, -9, -9, -9, -9, -9, -3}
    };
    int exp_cls [NV] = '{2, 2, 2, 0, 0, 9, 2};
    int exp_mx  [NV] = '{7, 32'hFFFF, 7, 5, 32'h7FFF, 100, 32'hFFFD};
    int use_gap [NV] = '{0, 0, 1, 0, 1, 0, 0};

    int tests  = 0;
    int failed = 0;
    int exp_frames = 0;
    int exp_pulses = 0;
    int pulses = 0;
    int hold_err = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Passive monitor: counts pulses and flags result changes without o_valid.
    logic          rst_seen = 1'b1;
    logic [IW-1:0] prev_class;
    logic [DW-1:0] prev_max;

    always @(posedge clk) begin
        rst_seen <= rst;
        cyc++;
    end

    always @(negedge clk) begin
        if (o_valid === 1'b1) pulses++;
        if (!rst_seen && !o_valid && (o_class !== prev_class || o_max !== prev_max)) hold_err++;
        prev_class = o_class;
        prev_max   = o_max;
    end

    task automatic drive_beats(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = tbl[k].data[i];
        end
    endtask

    task automatic drive_frame(input int k, input bit first_now);
        for (int i = 0; i < N; i++) begin
            if (tbl[k].gaps && i > 0) begin
                int g = $urandom_range(0, 3);
                repeat (g) begin
                    @(negedge clk);
                    i_valid = 1'b0;
                    check("gap_no_pulse", 32'(o_valid), 0);
                    check("gap_busy", 32'(o_busy), 1);
                end
            end
            if (!(first_now && i == 0)) @(negedge clk);
            check(i == 0 ? "busy_idle" : "busy_accum", 32'(o_busy), (i == 0) ? 0 : 1);
            if (i > 0) check("early_pulse", 32'(o_valid), 0);
            i_valid = 1'b1;
            i_data  = tbl[k].data[i];
        end
    endtask

    task automatic check_result(input int k);
        @(negedge clk);
        exp_frames++;
        exp_pulses++;
        check($sformatf("pulse[%0d]", k), 32'(o_valid), 1);
        check($sformatf("class[%0d]", k), 32'(o_class), 32'(tbl[k].exp_class));
        check($sformatf("max[%0d]", k), 32'(o_max), 32'(tbl[k].exp_max));
        check($sformatf("frame_cnt[%0d]", k), 32'(o_frame_cnt), 32'(exp_frames[15:0]));
    endtask

    task automatic idle_after();
        i_valid = 1'b0;
        @(negedge clk);
        check("pulse_width", 32'(o_valid), 0);
        check("busy_after", 32'(o_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t1;
        int t2;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_data  = '0;
        for (int k = 0; k < NV; k++) begin
            for (int i = 0; i < N; i++) tbl[k].data[i] = vals[k][i][DW-1:0];
            tbl[k].gaps      = (use_gap[k] != 0);
            tbl[k].exp_class = exp_cls[k][IW-1:0];
            tbl[k].exp_max   = exp_mx[k][DW-1:0];
        end

        repeat (3) @(negedge clk);
        check("rst_class", 32'(o_class), 0);
        check("rst_max", 32'(o_max), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_frame_cnt", 32'(o_frame_cnt), 0);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            if (k == 5) continue;
            drive_frame(k, 1'b0);
            check_result(k);
            idle_after();
        end

        // Back-to-back frames: the second frame's first beat rides the pulse cycle.
        drive_frame(0, 1'b0);
        check_result(0);
        t1 = cyc;
        drive_frame(5, 1'b1);
        check_result(5);
        t2 = cyc;
        check("b2b_spacing", 32'(t2 - t1), 10);
        idle_after();

        // Flush together with beat 5, then a complete frame.
        drive_beats(0, 4);
        @(negedge clk);
        i_data  = tbl[0].data[4];
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_busy", 32'(o_busy), 0);
        check("flush_no_pulse", 32'(o_valid), 0);
        check("flush_frame_cnt", 32'(o_frame_cnt), 32'(exp_frames[15:0]));
        drive_frame(1, 1'b0);
        check_result(1);
        idle_after();

        // Flush together with the last beat: that beat must be discarded.
        drive_beats(5, 9);
        @(negedge clk);
        i_data  = tbl[5].data[9];
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_last_no_pulse", 32'(o_valid), 0);
        check("flush_last_busy", 32'(o_busy), 0);
        check("flush_last_frame_cnt", 32'(o_frame_cnt), 32'(exp_frames[15:0]));
        drive_frame(0, 1'b0);
        check_result(0);
        idle_after();

        // Reset after 4 beats, with a valid beat held during reset.
        drive_beats(0, 4);
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'h7FFF;
        @(negedge clk);
        check("mrst_class", 32'(o_class), 0);
        check("mrst_max", 32'(o_max), 0);
        check("mrst_valid", 32'(o_valid), 0);
        check("mrst_busy", 32'(o_busy), 0);
        check("mrst_frame_cnt", 32'(o_frame_cnt), 0);
        rst        = 1'b0;
        i_valid    = 1'b0;
        exp_frames = 0;
        drive_frame(6, 1'b0);
        check_result(6);
        idle_after();

        @(negedge clk);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        check("hold_between_pulses", 32'(hold_err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
